neurosync_medida_uc: RTL and testbench
======================================

# neurosync_medida_uc

Measurement sequencer for the NeuroSync distance-range mode. While the game controller holds `medir` high (aguarda_med_faixa), this block repeatedly fires the ultrasonic sensor interface, waits for each result or a timeout, and checks the distance against the question's range. It asserts `acertou_faixa` only after N consecutive in-range readings, which debounces the hand-position answer before the game controller moves to feedback.

## Interface
- `W`, 9: distance width in cm, unsigned.
- `N_ACERTOS`, 3: consecutive in-range readings required, 1..7.
- `INTERVALO`, 3_000_000: idle cycles between a completed reading and the next trigger (60 ms at 50 MHz).
- `TIMEOUT`, 2_500_000: maximum cycles to wait for `pronto_medida` after a trigger.

- `clock`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high; acts on the rising edge of `clock`.
- `medir`  in  1  level enable from the game controller.
- `pronto_medida`  in  1  one-cycle pulse from the sensor interface; `medida` is valid in the same cycle.
- `medida`  in  W  measured distance.
- `faixa_min`  in  W  inclusive lower bound; must be stable while `medir` is high.
- `faixa_max`  in  W  inclusive upper bound; must be stable while `medir` is high.
- `dispara`  out  1  one-cycle trigger pulse to the sensor interface.
- `acertou_faixa`  out  1  level; high while the block is in state acertou.
- `timeout`  out  1  one-cycle pulse when a reading was lost.
- `db_estado`  out  3  current state encoding, for debug.

## Operation
- States and `db_estado` encodings:
  - ocioso=000
  - dispara=001
  - aguarda=010
  - compara=011
  - espera=100
  - acertou=101
- Transitions:
  - ocioso: `medir`=1 → dispara; else stay.
  - dispara: → aguarda. Zero the cycle counter.
  - aguarda:
    - `pronto_medida`=1: capture `medida` into reg_medida → compara.
    - Else, cycle counter == TIMEOUT-1: assert `timeout`, clear hit counter → espera.
    - Else increment the cycle counter.
  - compara:
    - In range (`faixa_min` ≤ reg_medida ≤ `faixa_max`, unsigned): hits+1.
    - Out of range: hits=0.
    - Go to acertou if the new hits value == N_ACERTOS, else espera.
    - Zero the cycle counter on exit.
  - espera: go to dispara when the cycle counter == INTERVALO-1; else increment.
  - acertou: stay while `medir`=1.
- Global override: `medir`=0 in any state other than ocioso → next state is ocioso. Hits, cycle counter and reg_medida are cleared.
- Hit counter is 3 bits. It never exceeds N_ACERTOS.
- Cycle counter width is clog2(max(INTERVALO, TIMEOUT)).
- `faixa_min` > `faixa_max` → never in range; `acertou_faixa` never rises.
- `pronto_medida` outside aguarda is ignored: no capture, no state change.

## Timing
- Reset values:
  - state ocioso
  - `dispara`=0, `acertou_faixa`=0, `timeout`=0
  - `db_estado`=000
  - hits=0, cycle counter=0, reg_medida=0
- Moore outputs: `dispara` = (state==dispara), `acertou_faixa` = (state==acertou), `db_estado` = state.
- `timeout` is registered. It is high in the first cycle of espera that follows a timeout.
- `medir` sampled high at edge k → `dispara` high in cycle k+1 for exactly one cycle.
- `pronto_medida` at edge j → compara during cycle j+1 → acertou or espera from edge j+2.
- Trigger-to-trigger period after a valid reading: espera lasts INTERVALO cycles, plus 1 cycle compara and 1 cycle dispara.
- After a timeout: aguarda lasts TIMEOUT cycles after dispara, then espera lasts INTERVALO cycles.
- Simultaneous `pronto_medida` and timeout-terminal count in aguarda → `pronto_medida` wins; no `timeout` pulse.
- `medir` falling, including mid-aguarda or in acertou → ocioso at the next edge; `acertou_faixa` low from that edge.
- `reset` has priority over `medir` in the same cycle.

## Test plan
Bench parameters: W=9, N_ACERTOS=3, INTERVALO=4, TIMEOUT=8.

- Reset then idle: hold `medir`=0 for 10 cycles → outputs 0, `db_estado`=000 throughout; no `dispara`.
- Three hits: `faixa_min`=10, `faixa_max`=20. Raise `medir`, answer each `dispara` 2 cycles later with `pronto_medida`, `medida`=15 → exactly 3 `dispara` pulses. `acertou_faixa` rises 2 cycles after the third `pronto_medida` and holds while `medir`=1.
- Streak broken and bounds inclusive: send readings 10, 21, 20, 20, 10 → `acertou_faixa` rises only after the fifth reading. The out-of-range 21 resets hits, and both bounds count as hits.
- Timeout: never answer `dispara` → `timeout` pulses 8 cycles after aguarda is entered. Next `dispara` follows after 4 espera cycles. Hits reset, so 15, timeout, 15, 15 does not assert `acertou_faixa`.
- Collision and abort:
  - `pronto_medida` on the terminal timeout cycle → no `timeout` pulse; state goes to compara.
  - Drop `medir` mid-aguarda → `db_estado`=000 at the next edge. Re-raise `medir` → fresh count from 0 hits.
- Reset mid-run and empty range:
  - Assert `reset` while in acertou → all outputs 0 at the next edge.
  - `faixa_min`=30, `faixa_max`=20 with 6 readings of 25 → `acertou_faixa` stays 0.

Source files
------------

// File: rtl/neurosync_medida_uc.sv
// Measurement sequencer for the NeuroSync distance-range mode: triggers the ultrasonic
// sensor, waits for a reading or timeout, and debounces N consecutive in-range readings.
module neurosync_medida_uc #(
    parameter int unsigned W         = 9,
    parameter int unsigned N_ACERTOS = 3,
    parameter int unsigned INTERVALO = 3_000_000,
    parameter int unsigned TIMEOUT   = 2_500_000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         medir,
    input  logic         pronto_medida,
    input  logic [W-1:0] medida,
    input  logic [W-1:0] faixa_min,
    input  logic [W-1:0] faixa_max,
    output logic         dispara,
    output logic         acertou_faixa,
    output logic         timeout,
    output logic [2:0]   db_estado
);

    localparam int unsigned CntMax = (INTERVALO > TIMEOUT) ? INTERVALO : TIMEOUT;
    localparam int unsigned CW     = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam logic [CW-1:0] TimeoutLast   = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] IntervaloLast = CW'(INTERVALO - 1);
    localparam logic [2:0]    NHits         = 3'(N_ACERTOS);

    typedef enum logic [2:0] {
        StOcioso  = 3'b000,
        StDispara = 3'b001,
        StAguarda = 3'b010,
        StCompara = 3'b011,
        StEspera  = 3'b100,
        StAcertou = 3'b101
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic [2:0]    hits;
    logic [W-1:0]  reg_medida;
    logic          na_faixa;
    logic [2:0]    hits_prox;

    // An inverted range (min > max) can never satisfy both bounds.
    always_comb begin
        na_faixa  = (reg_medida >= faixa_min) && (reg_medida <= faixa_max);
        hits_prox = na_faixa ? hits + 3'd1 : 3'd0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado     <= StOcioso;
            cnt        <= '0;
            hits       <= '0;
            reg_medida <= '0;
            timeout    <= 1'b0;
        end else if (!medir && estado != StOcioso) begin
            estado     <= StOcioso;
            cnt        <= '0;
            hits       <= '0;
            reg_medida <= '0;
            timeout    <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (estado)
                StOcioso: begin
                    if (medir) estado <= StDispara;
                end
                StDispara: begin
                    cnt    <= '0;
                    estado <= StAguarda;
                end
                StAguarda: begin
                    // A reading on the terminal count still counts; no timeout pulse.
                    if (pronto_medida) begin
                        reg_medida <= medida;
                        estado     <= StCompara;
                    end else if (cnt == TimeoutLast) begin
                        timeout <= 1'b1;
                        hits    <= '0;
                        cnt     <= '0;
                        estado  <= StEspera;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StCompara: begin
                    hits   <= hits_prox;
                    cnt    <= '0;
                    estado <= (hits_prox == NHits) ? StAcertou : StEspera;
                end
                StEspera: begin
                    if (cnt == IntervaloLast) begin
                        cnt    <= '0;
                        estado <= StDispara;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                StAcertou: begin
                    estado <= StAcertou;
                end
                default: begin
                    estado <= StOcioso;
                end
            endcase
        end
    end

    always_comb begin
        dispara       = (estado == StDispara);
        acertou_faixa = (estado == StAcertou);
        db_estado     = estado;
    end

endmodule

// File: tb/tb_neurosync_medida_uc.sv
// Scenario bench for neurosync_medida_uc; expected post-compare state/acertou come from a
// bench-side hit model pushed to a queue when each reading is driven.
module tb_neurosync_medida_uc;

    localparam int unsigned W = 9;
    localparam int unsigned N = 3;

    logic         clock = 1'b0;
    logic         reset;
    logic         medir;
    logic         pronto_medida;
    logic [W-1:0] medida;
    logic [W-1:0] faixa_min;
    logic [W-1:0] faixa_max;
    logic         dispara;
    logic         acertou_faixa;
    logic         timeout;
    logic [2:0]   db_estado;

    int checks = 0;
    int errors = 0;
    int hits_m = 0;
    logic [3:0] exp_q[$];

    neurosync_medida_uc #(
        .W         (W),
        .N_ACERTOS (N),
        .INTERVALO (4),
        .TIMEOUT   (8)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .medir         (medir),
        .pronto_medida (pronto_medida),
        .medida        (medida),
        .faixa_min     (faixa_min),
        .faixa_max     (faixa_max),
        .dispara       (dispara),
        .acertou_faixa (acertou_faixa),
        .timeout       (timeout),
        .db_estado     (db_estado)
    );

    always #5 clock = ~clock;

    task automatic model_push(input logic [W-1:0] v);
        if (v >= faixa_min && v <= faixa_max) hits_m++;
        else hits_m = 0;
        exp_q.push_back((hits_m == N) ? 4'b1101 : 4'b0100);
    endtask

    task automatic check_pop(input string name);
        logic [3:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, {acertou_faixa, db_estado});
        end else begin
            e = exp_q.pop_front();
            if ({acertou_faixa, db_estado} !== e) begin
                errors++;
                $display("FAIL %s: got {acertou,estado}=%b required %b", name,
                         {acertou_faixa, db_estado}, e);
            end
        end
    endtask

    task automatic wait_dispara();
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clock);
            if (dispara === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_dispara: got no dispara, required dispara=1 within 40 cycles");
        end
    endtask

    // Called at the negedge of the dispara cycle.
    task automatic answer(input logic [W-1:0] v);
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (dispara !== 1'b0 || db_estado !== 3'b010) begin
            errors++;
            $display("FAIL dispara_width: got dispara=%b estado=%b required 0 010",
                     dispara, db_estado);
        end
        @(posedge clock);
        #1 pronto_medida = 1'b1;
        medida = v;
        model_push(v);
        @(posedge clock);
        #1 pronto_medida = 1'b0;
        @(negedge clock);
        checks++;
        if (db_estado !== 3'b011) begin
            errors++;
            $display("FAIL compara: got estado=%b required 011", db_estado);
        end
        @(posedge clock);
        @(negedge clock);
        check_pop("post_compara");
    endtask

    task automatic do_reading(input logic [W-1:0] v);
        wait_dispara();
        answer(v);
    endtask

    task automatic go_idle();
        @(posedge clock);
        #1 medir = 1'b0;
        repeat (3) @(posedge clock);
        #1 hits_m = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1; medir = 1'b0; pronto_medida = 1'b0;
        medida = '0; faixa_min = '0; faixa_max = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if ({dispara, acertou_faixa, timeout, db_estado} !== 6'b0) begin
                errors++;
                $display("FAIL idle: got {disp,acert,to,estado}=%b required 000000",
                         {dispara, acertou_faixa, timeout, db_estado});
            end
        end
    endtask

    task automatic test_three_hits();
        faixa_min = 9'd10; faixa_max = 9'd20;
        @(posedge clock);
        #1 medir = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (dispara !== 1'b1) begin
            errors++;
            $display("FAIL dispara_latency: got %b required 1", dispara);
        end
        answer(9'd15);
        do_reading(9'd15);
        do_reading(9'd15);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checks++;
            if (acertou_faixa !== 1'b1 || dispara !== 1'b0) begin
                errors++;
                $display("FAIL acertou_hold: got acert=%b disp=%b required 1 0",
                         acertou_faixa, dispara);
            end
        end
        go_idle();
    endtask

    task automatic test_streak();
        logic [W-1:0] vals [5] = '{9'd10, 9'd21, 9'd20, 9'd20, 9'd10};
        faixa_min = 9'd10; faixa_max = 9'd20;
        #1 medir = 1'b1;
        for (int i = 0; i < 5; i++) do_reading(vals[i]);
        go_idle();
    endtask

    task automatic test_timeout();
        faixa_min = 9'd10; faixa_max = 9'd20;
        #1 medir = 1'b1;
        do_reading(9'd15);
        wait_dispara();
        @(posedge clock);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (timeout !== (k == 8)) begin
                errors++;
                $display("FAIL timeout_pulse k=%0d: got %b required %b", k, timeout, k == 8);
            end
        end
        checks++;
        if (db_estado !== 3'b100) begin
            errors++;
            $display("FAIL timeout_state: got %b required 100", db_estado);
        end
        hits_m = 0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (dispara !== (k == 4) || timeout !== 1'b0) begin
                errors++;
                $display("FAIL espera_len k=%0d: got disp=%b to=%b required %b 0", k, dispara,
                         timeout, k == 4);
            end
        end
        answer(9'd15);
        do_reading(9'd15);
        go_idle();
    endtask

    task automatic test_collision_abort();
        faixa_min = 9'd10; faixa_max = 9'd20;
        #1 medir = 1'b1;
        wait_dispara();
        @(posedge clock);
        repeat (7) @(posedge clock);
        #1 pronto_medida = 1'b1;
        medida = 9'd15;
        model_push(9'd15);
        @(posedge clock);
        #1 pronto_medida = 1'b0;
        @(negedge clock);
        checks++;
        if (db_estado !== 3'b011 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL collision: got estado=%b to=%b required 011 0", db_estado, timeout);
        end
        @(posedge clock);
        @(negedge clock);
        check_pop("collision_post");
        wait_dispara();
        @(posedge clock);
        @(posedge clock);
        #1 medir = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (db_estado !== 3'b000) begin
            errors++;
            $display("FAIL abort: got estado=%b required 000", db_estado);
        end
        hits_m = 0;
        @(posedge clock);
        #1 medir = 1'b1;
        for (int i = 0; i < 3; i++) do_reading(9'd15);
    endtask

    task automatic test_reset_empty();
        @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if ({dispara, acertou_faixa, timeout, db_estado} !== 6'b0) begin
            errors++;
            $display("FAIL reset_mid: got {disp,acert,to,estado}=%b required 000000",
                     {dispara, acertou_faixa, timeout, db_estado});
        end
        medir = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        go_idle();
        faixa_min = 9'd30; faixa_max = 9'd20;
        #1 medir = 1'b1;
        for (int i = 0; i < 6; i++) do_reading(9'd25);
        @(negedge clock);
        checks++;
        if (acertou_faixa !== 1'b0) begin
            errors++;
            $display("FAIL empty_range: got acertou=%b required 0", acertou_faixa);
        end
        go_idle();
    endtask

    initial begin
        test_reset();
        test_three_hits();
        test_streak();
        test_timeout();
        test_collision_abort();
        test_reset_empty();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
